// File: rtl/fir_decim_buffer.sv
// Decimating block accumulator behind the 2-tap FIR: sums DECIM samples per block
// and queues the sums in a small FIFO read through a valid/ready handshake.
module fir_decim_buffer #(
  parameter int BW_IN  = 3,
  parameter int DECIM  = 4,
  parameter int BW_ACC = BW_IN + $clog2(DECIM),
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [BW_IN-1:0]    y_in,
  input  logic                       y_en,
  output logic signed [BW_ACC-1:0]   out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);

  localparam int CW = $clog2(DECIM);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DECIM - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic signed [BW_ACC-1:0] acc_q, acc_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]            level_q, level_d;
  logic                     overflow_q, overflow_d;
  logic signed [BW_ACC-1:0] out_data_q, out_data_d;
  logic signed [BW_ACC-1:0] mem_q [DEPTH];
  logic signed [BW_ACC-1:0] mem_d [DEPTH];

  logic signed [BW_ACC-1:0] y_sext;
  logic signed [BW_ACC-1:0] sum;
  logic                     blk_done;
  logic                     do_pop;
  logic                     do_push;

  always_comb begin
    y_sext   = {{(BW_ACC-BW_IN){y_in[BW_IN-1]}}, y_in};
    sum      = acc_q + y_sext;
    blk_done = y_en && (cnt_q == CNT_LAST);
    do_pop   = (level_q != '0) && out_ready;
    // A full FIFO still accepts the new sum when the head leaves on the same edge.
    do_push  = blk_done && ((level_q != LVL_FULL) || do_pop);

    acc_d      = acc_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    mem_d      = mem_q;

    if (y_en) begin
      if (blk_done) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (blk_done && !do_push) overflow_d = 1'b1;

    if (do_push) begin
      mem_d[wr_ptr_q] = sum;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;

    if (do_push && !do_pop)      level_d = level_q + 1'b1;
    else if (do_pop && !do_push) level_d = level_q - 1'b1;

    // Head register follows the new head; holds its last value when the FIFO empties.
    out_data_d = (level_d != '0) ? mem_d[rd_ptr_d] : out_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      out_data_q <= '0;
      mem_q      <= '{default: '0};
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      out_data_q <= out_data_d;
      mem_q      <= mem_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = (level_q != '0);
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Self-checking bench for fir_decim_buffer: directed scenarios plus random traffic
// compared against a queue-based model of block sums and the output FIFO.
module tb_fir_decim_buffer;

  localparam int BW_IN  = 3;
  localparam int DECIM  = 4;
  localparam int BW_ACC = BW_IN + $clog2(DECIM);
  localparam int DEPTH  = 4;

  logic                      clk;
  logic                      reset;
  logic signed [BW_IN-1:0]   y_in;
  logic                      y_en;
  logic signed [BW_ACC-1:0]  out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [$clog2(DEPTH):0]    level;
  logic                      overflow;

  int checks = 0;
  int errors = 0;

  int mq[$];
  int blk[$];
  bit m_ovf = 0;

  fir_decim_buffer #(
    .BW_IN (BW_IN),
    .DECIM (DECIM),
    .BW_ACC(BW_ACC),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .y_in     (y_in),
    .y_en     (y_en),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level    (level),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: apply inputs, advance the model by the same edge, compare after the edge.
  task automatic cyc(input bit rst, input bit en, input int y, input bit rdy);
    int s;
    bit pop;
    reset     = rst;
    y_en      = en;
    y_in      = y[BW_IN-1:0];
    out_ready = rdy;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      blk.delete();
      m_ovf = 0;
    end else begin
      pop = (mq.size() > 0) && rdy;
      if (pop) void'(mq.pop_front());
      if (en) begin
        blk.push_back(y);
        if (blk.size() == DECIM) begin
          s = 0;
          foreach (blk[i]) s += blk[i];
          blk.delete();
          if (mq.size() == DEPTH) m_ovf = 1;
          else mq.push_back(s);
        end
      end
    end
    #1;
    check("out_valid", int'(out_valid), int'(mq.size() != 0));
    check("level", int'(level), mq.size());
    check("overflow", int'(overflow), int'(m_ovf));
    if (mq.size() != 0) check("out_data", int'($signed(out_data)), mq[0]);
    if (rst) check("out_data_rst", int'($signed(out_data)), 0);
  endtask

  task automatic block(input int a, input int b, input int c, input int d, input bit rdy);
    cyc(0, 1, a, rdy);
    cyc(0, 1, b, rdy);
    cyc(0, 1, c, rdy);
    cyc(0, 1, d, rdy);
  endtask

  initial begin
    reset = 1'b1; y_en = 1'b0; y_in = '0; out_ready = 1'b0;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);

    // Basic sum
    block(1, 2, 3, -1, 1);
    check("basic_valid", int'(out_valid), 1);
    check("basic_sum", int'($signed(out_data)), 5);
    cyc(0, 0, 0, 1);
    check("basic_drain_level", int'(level), 0);

    // Extremes
    block(-4, -4, -4, -4, 1);
    check("neg_extreme", int'($signed(out_data)), -16);
    block(3, 3, 3, 3, 1);
    check("pos_extreme", int'($signed(out_data)), 12);
    cyc(0, 0, 0, 1);

    // Gapped input
    cyc(0, 1, 1, 1); repeat (3) cyc(0, 0, 2, 1);
    cyc(0, 1, 2, 1); repeat (3) cyc(0, 0, -3, 1);
    cyc(0, 1, 3, 1); repeat (3) cyc(0, 0, 1, 1);
    cyc(0, 1, -1, 1);
    check("gap_sum", int'($signed(out_data)), 5);
    cyc(0, 0, 0, 1);

    // Overflow
    cyc(1, 0, 0, 0);
    block(1, 0, 0, 0, 0);
    block(2, 0, 0, 0, 0);
    block(3, 0, 0, 0, 0);
    block(2, 2, 0, 0, 0);
    block(3, 2, 0, 0, 0);
    check("ovf_level", int'(level), 4);
    check("ovf_flag", int'(overflow), 1);
    check("ovf_head", int'($signed(out_data)), 1);
    repeat (5) cyc(0, 0, 0, 1);
    check("ovf_empty", int'(out_valid), 0);
    check("ovf_sticky", int'(overflow), 1);

    // Full with simultaneous push and pop
    cyc(1, 0, 0, 0);
    block(1, 0, 0, 0, 0);
    block(2, 0, 0, 0, 0);
    block(3, 0, 0, 0, 0);
    block(2, 2, 0, 0, 0);
    cyc(0, 1, 3, 0); cyc(0, 1, 2, 0); cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 1);
    check("pp_level", int'(level), 4);
    check("pp_overflow", int'(overflow), 0);
    check("pp_head", int'($signed(out_data)), 2);
    repeat (5) cyc(0, 0, 0, 1);

    // Reset mid-operation
    block(1, 0, 0, 0, 0);
    cyc(0, 1, 3, 0); cyc(0, 1, 3, 0);
    cyc(1, 0, 0, 0);
    check("rst_level", int'(level), 0);
    check("rst_overflow", int'(overflow), 0);
    block(1, 1, 1, 1, 0);
    check("rst_level_after", int'(level), 1);
    check("rst_sum", int'($signed(out_data)), 4);
    cyc(0, 0, 0, 1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 1) == 1),
          int'($urandom_range(0, 7)) - 4, ($urandom_range(0, 9) < 6));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
